// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The feature macro UART_TX_ARB_GAP_TIMEOUT_EN is consumed by uart_tx_arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POLL      = 3'd1,
        WAIT_STAT = 3'd2,
        HOLD      = 3'd3,
        WRITE     = 3'd4,
        WAIT_WR   = 3'd5
    } state_t;

    localparam logic [31:0] UART_TX_REG            = 32'h0000_0004;
    localparam logic [31:0] UART_STATUS_REG        = 32'h0000_0008;
    localparam int          UART_STATUS_TXFULL_BIT = 1;
    localparam logic [15:0] GAP_TIMEOUT            = 16'hFFFF;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin requester pick plus the rotating priority pointer.
// The pointer only moves when a grant ends, to the slot after the holder.
module uart_rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] valid,
    input  logic              update,
    input  logic [IdxW-1:0]   holder,
    output logic              pick_valid,
    output logic [IdxW-1:0]   pick_idx
);

    logic [IdxW-1:0] ptr_r;
    logic [IdxW-1:0] next_ptr_s;
    logic [IdxW-1:0] cand_s;

    assign next_ptr_s = (holder == IdxW'(NumReq - 1)) ? '0 : holder + IdxW'(1);

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (update) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Scanning from the far end lets the slot nearest the pointer win last
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_s     = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand_s     = IdxW'((int'(ptr_r) + i) % NumReq);
            pick_valid = pick_valid | valid[cand_s];
            pick_idx   = valid[cand_s] ? cand_s : pick_idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of a UART TX register over a device bus.
// Define UART_TX_ARB_GAP_TIMEOUT_EN to abort grants whose holder stalls too long.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NumReq   = 2,
    parameter logic [31:0] UartBase = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [8*NumReq-1:0] req_data_i,
    input  logic [NumReq-1:0]   req_last_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic [NumReq-1:0]   gnt_o,
    output logic                busy_o,
    output logic                device_req_o,
    output logic [31:0]         device_addr_o,
    output logic                device_we_o,
    output logic [3:0]          device_be_o,
    output logic [31:0]         device_wdata_o,
    input  logic                device_rvalid_i,
    input  logic [31:0]         device_rdata_i,
    output logic                timeout_o
);

    localparam int          IdxW      = $clog2(NumReq);
    localparam logic [31:0] POLL_ADDR = UartBase + UART_STATUS_REG;
    localparam logic [31:0] WR_ADDR   = UartBase + UART_TX_REG;

    state_t          state_r;
    logic [IdxW-1:0] hold_idx_r;
    logic            last_r;
    logic            pick_valid_s;
    logic [IdxW-1:0] pick_idx_s;
    logic            hold_valid_s;
    logic [7:0]      hold_byte_s;
    logic            tx_full_s;
    logic            abort_s;
    logic            upd_s;
    logic            unused_rdata_s;

    function automatic logic [NumReq-1:0] onehot(input logic [IdxW-1:0] idx);
        return {{(NumReq-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign hold_valid_s   = req_valid_i[hold_idx_r];
    assign hold_byte_s    = req_data_i[{hold_idx_r, 3'b000} +: 8];
    assign tx_full_s      = device_rdata_i[UART_STATUS_TXFULL_BIT];
    assign unused_rdata_s = ^{device_rdata_i[31:2], device_rdata_i[0]};
    assign upd_s          = ((state_r == WAIT_WR) && device_rvalid_i && last_r) || abort_s;

`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
    logic [15:0] gap_r;
    assign abort_s = (state_r == HOLD) && !hold_valid_s && (gap_r == GAP_TIMEOUT);
`else
    assign abort_s   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    uart_rr_arbiter #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr (
        .clk        (clk_i),
        .rst        (rst_i),
        .valid      (req_valid_i),
        .update     (upd_s),
        .holder     (hold_idx_r),
        .pick_valid (pick_valid_s),
        .pick_idx   (pick_idx_s)
    );

    // Transfer FSM; bus strobes are set on the edge that enters POLL/WRITE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            hold_idx_r     <= '0;
            last_r         <= 1'b0;
            gnt_o          <= '0;
            busy_o         <= 1'b0;
            req_ready_o    <= '0;
            device_req_o   <= 1'b0;
            device_addr_o  <= 32'h0000_0000;
            device_we_o    <= 1'b0;
            device_be_o    <= 4'b0000;
            device_wdata_o <= 32'h0000_0000;
`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
            gap_r          <= 16'h0000;
            timeout_o      <= 1'b0;
`endif
        end else begin
            req_ready_o    <= '0;
            device_req_o   <= 1'b0;
            device_addr_o  <= 32'h0000_0000;
            device_we_o    <= 1'b0;
            device_be_o    <= 4'b0000;
            device_wdata_o <= 32'h0000_0000;
`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
            timeout_o      <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        hold_idx_r    <= pick_idx_s;
                        gnt_o         <= onehot(pick_idx_s);
                        busy_o        <= 1'b1;
                        state_r       <= POLL;
                        device_req_o  <= 1'b1;
                        device_addr_o <= POLL_ADDR;
                        device_be_o   <= 4'b0001;
                    end else begin
                        gnt_o   <= '0;
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                POLL: state_r <= WAIT_STAT;
                WAIT_STAT: begin
                    if (!device_rvalid_i) begin
                        state_r <= WAIT_STAT;
                    end else if (tx_full_s) begin
                        state_r       <= POLL;
                        device_req_o  <= 1'b1;
                        device_addr_o <= POLL_ADDR;
                        device_be_o   <= 4'b0001;
                    end else if (hold_valid_s) begin
                        state_r        <= WRITE;
                        device_req_o   <= 1'b1;
                        device_we_o    <= 1'b1;
                        device_addr_o  <= WR_ADDR;
                        device_be_o    <= 4'b0001;
                        device_wdata_o <= {24'h00_0000, hold_byte_s};
                        req_ready_o    <= onehot(hold_idx_r);
                        last_r         <= req_last_i[hold_idx_r];
                    end else begin
                        state_r <= HOLD;
`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
                        gap_r   <= 16'h0000;
`endif
                    end
                end
                HOLD: begin
                    // FIFO space may have been taken meanwhile, so re-poll first
                    if (hold_valid_s) begin
                        state_r       <= POLL;
                        device_req_o  <= 1'b1;
                        device_addr_o <= POLL_ADDR;
                        device_be_o   <= 4'b0001;
                    end else if (abort_s) begin
                        gnt_o     <= '0;
                        busy_o    <= 1'b0;
                        state_r   <= IDLE;
`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
                        timeout_o <= 1'b1;
`endif
                    end else begin
                        state_r <= HOLD;
`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
                        gap_r   <= gap_r + 16'h0001;
`endif
                    end
                end
                WRITE: state_r <= WAIT_WR;
                WAIT_WR: begin
                    if (!device_rvalid_i) begin
                        state_r <= WAIT_WR;
                    end else if (last_r) begin
                        gnt_o   <= '0;
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r       <= POLL;
                        device_req_o  <= 1'b1;
                        device_addr_o <= POLL_ADDR;
                        device_be_o   <= 4'b0001;
                    end
                end
                default: begin
                    gnt_o   <= '0;
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a UART slave model.
// Covers the gap-timeout path only when UART_TX_ARB_GAP_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_last = 2'b00;
    logic [1:0]  req_ready_o;
    logic [1:0]  gnt_o;
    logic        busy_o;
    logic        device_req_o;
    logic [31:0] device_addr_o;
    logic        device_we_o;
    logic [3:0]  device_be_o;
    logic [31:0] device_wdata_o;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    logic [8:0]  rq0[$];
    logic [8:0]  rq1[$];
    logic [31:0] stat_q[$];
    logic [31:0] wr_q[$];
    logic [1:0]  gnt_q[$];
    int nreq = 0, nrd = 0, nwr = 0, rd_at_wr = 0, nrdy0 = 0, nrdy1 = 0, nto = 0, viol = 0;
    logic pend = 1'b0, force_rv = 1'b0, drop_wr = 1'b0, prev_req = 1'b0;
    logic [31:0] pend_data = 32'h0;

    uart_tx_arbiter #(.NumReq(2), .UartBase(BASE)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready_o), .gnt_o(gnt_o), .busy_o(busy_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o),
        .device_we_o(device_we_o), .device_be_o(device_be_o),
        .device_wdata_o(device_wdata_o), .device_rvalid_i(rvalid),
        .device_rdata_i(rdata), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Requesters: present queue heads, retire a byte when ready is seen
    initial forever begin
        logic [8:0] tmp;
        @(negedge clk);
        if (req_ready_o[0]) nrdy0++;
        if (req_ready_o[1]) nrdy1++;
        if (req_ready_o[0] && rq0.size() > 0) tmp = rq0.pop_front();
        if (req_ready_o[1] && rq1.size() > 0) tmp = rq1.pop_front();
        req_valid[0]   = (rq0.size() > 0);
        req_data[7:0]  = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
        req_last[0]    = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
        req_valid[1]   = (rq1.size() > 0);
        req_data[15:8] = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
        req_last[1]    = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
    end

    // UART slave: answers each request one cycle later; also tallies protocol violations
    initial forever begin
        @(negedge clk);
        if (timeout_o) nto++;
        if ($countones(gnt_o) > 1) viol++;
        if (req_ready_o != 2'b00 && !(device_req_o && device_we_o)) viol++;
        if (device_req_o) begin
            if (prev_req) viol++;
            if (device_be_o != 4'b0001) viol++;
            if (device_we_o && device_addr_o != BASE + 32'h4) viol++;
            if (!device_we_o && device_addr_o != BASE + 32'h8) viol++;
            if (!device_we_o && device_wdata_o != 32'h0) viol++;
        end else begin
            if (device_be_o != 4'b0000 || device_wdata_o != 32'h0) viol++;
        end
        prev_req = device_req_o;
        rvalid = pend | force_rv;
        rdata  = pend ? pend_data : 32'h0;
        pend   = 1'b0;
        if (device_req_o) begin
            nreq++;
            if (device_we_o) begin
                nwr++;
                rd_at_wr = nrd;
                wr_q.push_back(device_wdata_o);
                gnt_q.push_back(gnt_o);
                pend = !drop_wr;
                pend_data = 32'h0;
            end else begin
                nrd++;
                pend = 1'b1;
                if (stat_q.size() > 0) pend_data = stat_q.pop_front();
                else pend_data = 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (wr_q.size() > i) ? wr_q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [1:0] gnt_at(input int i);
        return (gnt_q.size() > i) ? gnt_q[i] : 2'b11;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || busy_o) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_done"}, 32'(n < budget), 32'd1);
    endtask

    task automatic clear_log();
        wr_q.delete();
        gnt_q.delete();
    endtask

    initial begin
        int n, k, s_rd, s_wr, s_req, r0;
        logic anyb;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {device_req_o, device_we_o, device_be_o, busy_o, gnt_o, req_ready_o, timeout_o}, 32'h0);
        chk("reset_addr", device_addr_o, 32'h0);
        chk("reset_wdata", device_wdata_o, 32'h0);
        rst_i = 1'b0;

        // idle with no requests
        s_req = nreq; anyb = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            anyb = anyb | busy_o | (|gnt_o);
        end
        chk("idle_no_req", nreq - s_req, 0);
        chk("idle_busy_gnt", 32'(anyb), 0);

        // single byte from req0
        clear_log(); s_rd = nrd; s_wr = nwr; r0 = nrdy0;
        rq0.push_back({1'b1, 8'h41});
        n = 0;
        while (!device_req_o && n < 50) begin @(posedge clk); #1; n++; end
        chk("single_start", 32'(n < 50), 1);
        chk("single_gnt_o", gnt_o, 2'b01);
        k = 0;
        while (busy_o && k < 50) begin @(posedge clk); #1; k++; end
        chk("single_latency", k, 4);
        chk("single_reads", nrd - s_rd, 1);
        chk("single_writes", nwr - s_wr, 1);
        chk("single_wdata", wr_at(0), 32'h0000_0041);
        chk("single_ready0", nrdy0 - r0, 1);
        chk("single_idle_gnt", gnt_o, 2'b00);

        // full FIFO: three busy polls before the write
        clear_log(); s_rd = nrd; s_wr = nwr;
        stat_q.push_back(32'h2); stat_q.push_back(32'h2);
        stat_q.push_back(32'h2); stat_q.push_back(32'h0);
        rq1.push_back({1'b1, 8'h5A});
        wait_done("full", 200);
        chk("full_reads", nrd - s_rd, 4);
        chk("full_reads_before_wr", rd_at_wr - s_rd, 4);
        chk("full_writes", nwr - s_wr, 1);
        chk("full_wdata", wr_at(0), 32'h0000_005A);
        chk("full_gnt", gnt_at(0), 2'b10);

        // packet lock and round robin from a fresh pointer
        rst_i = 1'b1; @(posedge clk); #1; rst_i = 1'b0;
        clear_log();
        rq0.push_back({1'b0, 8'h41}); rq0.push_back({1'b1, 8'h42});
        rq1.push_back({1'b1, 8'h43});
        wait_done("lock", 300);
        chk("lock_count", wr_q.size(), 3);
        chk("lock_w0", wr_at(0), 32'h41);
        chk("lock_w1", wr_at(1), 32'h42);
        chk("lock_w2", wr_at(2), 32'h43);
        chk("lock_g0", gnt_at(0), 2'b01);
        chk("lock_g1", gnt_at(1), 2'b01);
        chk("lock_g2", gnt_at(2), 2'b10);
        clear_log();
        rq0.push_back({1'b1, 8'h44});
        rq1.push_back({1'b1, 8'h45});
        wait_done("rr", 300);
        chk("rr_w0", wr_at(0), 32'h44);
        chk("rr_g0", gnt_at(0), 2'b01);
        chk("rr_w1", wr_at(1), 32'h45);
        chk("rr_g1", gnt_at(1), 2'b10);

        // mid-packet stall: no traffic while holding, re-poll on return
        clear_log(); r0 = nrdy0;
        rq0.push_back({1'b0, 8'h61});
        n = 0;
        while (nrdy0 == r0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("stall_first", 32'(n < 50), 1);
        repeat (10) @(posedge clk);
        #1;
        s_req = nreq; s_rd = nrd; s_wr = nwr;
        repeat (50) @(posedge clk);
        #1;
        chk("stall_quiet", nreq - s_req, 0);
        chk("stall_busy", 32'(busy_o), 1);
        chk("stall_gnt", gnt_o, 2'b01);
        rq0.push_back({1'b1, 8'h62});
        wait_done("stall", 100);
        chk("stall_repoll", nrd - s_rd, 1);
        chk("stall_writes", nwr - s_wr, 1);
        chk("stall_wdata", wr_at(1), 32'h62);

        // reset while waiting for the write response, stale rvalid afterwards
        drop_wr = 1'b1;
        rq0.push_back({1'b1, 8'h55});
        n = 0;
        while (!(device_req_o && device_we_o) && n < 50) begin @(posedge clk); #1; n++; end
        chk("rst_reach_write", 32'(n < 50), 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_ctl", {device_req_o, device_we_o, device_be_o, busy_o, gnt_o, req_ready_o, timeout_o}, 32'h0);
        chk("rst_addr_wdata", device_addr_o | device_wdata_o, 32'h0);
        rst_i = 1'b0; force_rv = 1'b1; drop_wr = 1'b0;
        @(posedge clk); #1;
        force_rv = 1'b0;
        s_req = nreq; anyb = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            anyb = anyb | busy_o | (|gnt_o);
        end
        chk("rst_stale_rvalid", nreq - s_req, 0);
        chk("rst_stays_idle", 32'(anyb), 0);

`ifdef UART_TX_ARB_GAP_TIMEOUT_EN
        // gap timeout aborts req0 and hands over to req1
        clear_log(); r0 = nrdy0;
        rq0.push_back({1'b0, 8'h71});
        n = 0;
        while (nrdy0 == r0 && n < 50) begin @(posedge clk); #1; n++; end
        rq1.push_back({1'b1, 8'h72});
        n = 0;
        while (!timeout_o && n < 70000) begin @(posedge clk); #1; n++; end
        chk("to_pulse", 32'(n < 70000), 1);
        chk("to_gnt_cleared", gnt_o, 2'b00);
        wait_done("to", 100);
        chk("to_count", nto, 1);
        chk("to_wdata", wr_at(1), 32'h72);
        chk("to_gnt_req1", gnt_at(1), 2'b10);
        chk("to_no_consume", nrdy0 - r0, 1);
`else
        chk("no_timeout", nto, 0);
`endif

        chk("protocol_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
